// File: rtl/rf_wordline_sequencer.sv
// rf_wordline_sequencer: sequences one one-hot register-file wordline per cycle across a burst of consecutive registers.
// Optional RF_ZERO_REG_SKIP_EN: beats at ZERO_REG keep their cycle but drive no wordline and raise wl_zero.
module rf_wordline_sequencer #(
  parameter int ADDR_W   = 6,
  parameter int LEN_W    = 3,
  parameter int ZERO_REG = 31
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [LEN_W-1:0]       req_len,
  input  logic                   stall,
  output logic [(1<<ADDR_W)-1:0] wl,
  output logic                   wl_valid,
  output logic [ADDR_W-1:0]      wl_index,
  output logic                   wl_last,
`ifdef RF_ZERO_REG_SKIP_EN
  output logic                   wl_zero,
`endif
  output logic                   busy
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic [LEN_W-1:0] rem, rem_n;
  logic last, accept;
  logic [DEPTH-1:0] one_hot;
  assign busy      = state == BURST;
  assign last      = busy && rem == '0;
  assign req_ready = !busy || (last && !stall);
  assign accept    = req_valid && req_ready;
  assign wl_valid  = busy;
  assign wl_index  = busy ? ptr : '0;
  assign wl_last   = last;
  assign one_hot   = {{(DEPTH-1){1'b0}}, 1'b1} << ptr;
`ifdef RF_ZERO_REG_SKIP_EN
  logic at_zero;
  assign at_zero = busy && ptr == ADDR_W'(ZERO_REG);
  assign wl_zero = at_zero;
  assign wl      = (busy && !at_zero) ? one_hot : '0;
`else
  localparam int ZERO_REG_UNUSED = ZERO_REG;
  assign wl = busy ? one_hot : '0;
`endif
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    rem_n   = rem;
    if (accept) begin
      state_n = BURST;
      ptr_n   = req_addr;
      rem_n   = req_len;
    end else if (busy && !stall) begin
      state_n = last ? IDLE : BURST;
      ptr_n   = last ? ptr : ptr + 1'b1;
      rem_n   = last ? rem : rem - 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      rem   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      rem   <= rem_n;
    end
endmodule
